// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: read-side master turning std-mode FIFO reads into a valid/ready stream with tlast.
// Define FIFO_READER_STATS_EN to add the stall_cycles/starve_cycles counters.
module fifo_stream_reader #(
  parameter int DATA_WIDTH        = 32,
  parameter int FIFO_READ_LATENCY = 1,
  parameter int SKID_DEPTH        = FIFO_READ_LATENCY + 1,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  num_beats,
  output logic                  busy,
  output logic                  done,
  output logic                  fifo_rd_en,
  input  logic                  fifo_empty,
  input  logic                  fifo_rd_rst_busy,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           starve_cycles
`endif
);
  localparam int PW = $clog2(SKID_DEPTH);
  localparam int CW = $clog2(SKID_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                  state, state_nxt;
  logic [CNT_WIDTH-1:0]    issue_rem, pop_rem;
  logic [FIFO_READ_LATENCY-1:0] pipe;
  logic [DATA_WIDTH-1:0]   mem [SKID_DEPTH];
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           skid_cnt, inflight;
  logic                    push, pop, accept, credit;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < FIFO_READ_LATENCY; i++) inflight = inflight + CW'(pipe[i]);
  end

  // a read is only issued if its data is guaranteed a skid slot on arrival
  assign credit     = (int'(inflight) + int'(skid_cnt) - int'(pop)) < SKID_DEPTH;
  assign fifo_rd_en = state == RUN && !fifo_empty && !fifo_rd_rst_busy && issue_rem != 0 && credit;
  assign push       = pipe[FIFO_READ_LATENCY-1];
  assign m_tvalid   = skid_cnt != 0;
  assign m_tdata    = mem[rd_ptr];
  assign m_tlast    = m_tvalid && pop_rem == 1;
  assign pop        = m_tvalid && m_tready;
  assign accept     = state == IDLE && start;

  always_comb begin
    state_nxt = state;
    busy      = state != IDLE;
    done      = state == DONE;
    state_nxt = accept ? (num_beats == 0 ? DONE : RUN)
              : (state == RUN && fifo_rd_en && issue_rem == 1) ? DRAIN
              : (state == DRAIN && pop && pop_rem == 1) ? DONE
              : state == DONE ? IDLE : state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      issue_rem <= '0;
      pop_rem   <= '0;
      pipe      <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      skid_cnt  <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        issue_rem <= num_beats;
        pop_rem   <= num_beats;
      end else begin
        if (fifo_rd_en) issue_rem <= issue_rem - 1'b1;
        if (pop && pop_rem != 0) pop_rem <= pop_rem - 1'b1;
      end
      pipe <= FIFO_READ_LATENCY'({pipe, fifo_rd_en});
      if (push) begin
        mem[wr_ptr] <= fifo_dout;
        wr_ptr      <= (wr_ptr == PW'(SKID_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == PW'(SKID_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      skid_cnt <= skid_cnt + CW'(push) - CW'(pop);
    end
  end

`ifdef FIFO_READER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles  <= '0;
      starve_cycles <= '0;
    end else if (accept) begin
      stall_cycles  <= '0;
      starve_cycles <= '0;
    end else begin
      if (m_tvalid && !m_tready && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
      if ((state == RUN || state == DRAIN) && !m_tvalid && pop_rem != 0 && starve_cycles != '1)
        starve_cycles <= starve_cycles + 1'b1;
    end
  end
`endif

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && skid_cnt == CW'(SKID_DEPTH)));
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: runs latency-1 and latency-2 readers side by side against a FIFO model
// and a transfer-level reference (words leave the FIFO in order and must reappear as beats in order).
module tb_fifo_stream_reader;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 0, rst_n = 0, start = 0, m_tready = 0, rrb = 0, flush = 0;
  logic [CW-1:0] num_beats = '0;
  logic [1:0]    busy, done, rd_en, empty, tvalid, tlast, rd_q;
  logic [DW-1:0] tdata [2];
  logic [DW-1:0] dout [2];
  logic [DW-1:0] d1 [2];
  logic [DW-1:0] d2 [2];
  logic [DW-1:0] mem [0:1023];
  int            wcnt = 0;
  int            rp [2] = '{0, 0};
  int            checks = 0, errors = 0, cyc = 0;
  int            rmode = 0, lit_last = -1;
  logic          rbmode = 0, tgl = 0, tp_chk = 0;

  logic          act [2], dn [2], stall_p [2], plast [2];
  logic [DW-1:0] pdata [2], last_data [2];
  int            nb [2], beats [2], reads [2], bp [2], first_rd [2], first_v [2], first_hs [2], last_hs [2];

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_WIDTH(DW), .FIFO_READ_LATENCY(1), .CNT_WIDTH(CW)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .num_beats(num_beats), .busy(busy[0]), .done(done[0]),
    .fifo_rd_en(rd_en[0]), .fifo_empty(empty[0]), .fifo_rd_rst_busy(rrb), .fifo_dout(dout[0]),
    .m_tdata(tdata[0]), .m_tvalid(tvalid[0]), .m_tready(m_tready), .m_tlast(tlast[0]));

  fifo_stream_reader #(.DATA_WIDTH(DW), .FIFO_READ_LATENCY(2), .CNT_WIDTH(CW)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .num_beats(num_beats), .busy(busy[1]), .done(done[1]),
    .fifo_rd_en(rd_en[1]), .fifo_empty(empty[1]), .fifo_rd_rst_busy(rrb), .fifo_dout(dout[1]),
    .m_tdata(tdata[1]), .m_tvalid(tvalid[1]), .m_tready(m_tready), .m_tlast(tlast[1]));

  // FIFO model: one shared word store, an independent read pointer per reader
  assign empty[0] = rp[0] == wcnt;
  assign empty[1] = rp[1] == wcnt;
  assign dout[0]  = d1[0];
  assign dout[1]  = d2[1];

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (flush) rp[g] <= wcnt;
      else if (rd_q[g] && rp[g] != wcnt) begin
        d1[g] <= mem[rp[g]];
        rp[g] <= rp[g] + 1;
      end
      d2[g] <= d1[g];
    end
  end

  task automatic chk(input bit ok, input string nm, input int g, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s lane%0d got %0h expected %0h at cycle %0d", nm, g, a, e, cyc);
    end
  endtask

  initial forever begin
    @(negedge clk);
    cyc++;
    for (int g = 0; g < 2; g++) begin
      rd_q[g] = rd_en[g];
      if (!rst_n) begin
        chk({busy[g], done[g], rd_en[g], tvalid[g], tlast[g], tdata[g]} == 0, "reset_outputs", g,
            {busy[g], done[g], rd_en[g], tvalid[g], tlast[g], tdata[g]}, 0);
        act[g] = 0; dn[g] = 0; stall_p[g] = 0;
      end else begin
        chk({busy[g], done[g]} == {act[g], dn[g]}, "busy_done", g, {busy[g], done[g]}, {act[g], dn[g]});
        if (rd_en[g]) begin
          chk({empty[g], rrb, act[g] && !dn[g] && reads[g] < nb[g]} == 3'b001, "rd_legal", g,
              {empty[g], rrb, act[g] && !dn[g] && reads[g] < nb[g]}, 3'b001);
          reads[g]++;
          if (first_rd[g] < 0) first_rd[g] = cyc;
        end
        if (stall_p[g])
          chk({tvalid[g], tlast[g], tdata[g]} == {1'b1, plast[g], pdata[g]}, "stable", g,
              {tvalid[g], tlast[g], tdata[g]}, {1'b1, plast[g], pdata[g]});
        if (tvalid[g]) begin
          if (first_v[g] < 0) begin
            first_v[g] = cyc;
            chk(first_rd[g] >= 0 && cyc - first_rd[g] >= g + 2, "latency", g, cyc - first_rd[g], g + 2);
          end
          chk({act[g] && !dn[g] && beats[g] < nb[g], tlast[g], tdata[g]} ==
              {1'b1, beats[g] == nb[g] - 1, mem[bp[g] + beats[g]]}, "beat", g,
              {act[g] && !dn[g] && beats[g] < nb[g], tlast[g], tdata[g]},
              {1'b1, beats[g] == nb[g] - 1, mem[bp[g] + beats[g]]});
        end else chk(tlast[g] == 0, "tlast_idle", g, tlast[g], 0);
        if (dn[g]) begin
          chk(reads[g] == nb[g], "reads_at_done", g, reads[g], nb[g]);
          if (lit_last >= 0 && nb[g] > 0) chk(last_data[g] == lit_last, "last_word", g, last_data[g], lit_last);
          if (tp_chk && nb[g] > 0) chk(last_hs[g] - first_hs[g] == nb[g] - 1, "throughput", g,
                                      last_hs[g] - first_hs[g], nb[g] - 1);
          act[g] = 0; dn[g] = 0;
        end else if (!act[g] && start) begin
          act[g] = 1; nb[g] = int'(num_beats); beats[g] = 0; reads[g] = 0; bp[g] = rp[g];
          first_rd[g] = -1; first_v[g] = -1; dn[g] = num_beats == 0;
        end else if (act[g] && tvalid[g] && m_tready) begin
          if (beats[g] == 0) first_hs[g] = cyc;
          last_hs[g] = cyc; last_data[g] = tdata[g];
          beats[g]++;
          dn[g] = beats[g] == nb[g];
        end
        stall_p[g] = tvalid[g] && !m_tready;
        pdata[g] = tdata[g];
        plast[g] = tlast[g];
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    tgl = ~tgl;
    m_tready = rmode == 0 ? 1'b1 : rmode == 1 ? tgl : 1'($urandom_range(0, 1));
    rrb = rbmode && $urandom_range(0, 5) == 0;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic [DW-1:0] w);
    mem[wcnt] = w;
    wcnt++;
  endtask

  task automatic do_flush();
    flush = 1; tick(); flush = 0;
  endtask

  task automatic go(input int n);
    num_beats = CW'(n); start = 1; tick(); start = 0;
  endtask

  task automatic wait_idle(input int feed);
    int t = 0;
    while ((act[0] || act[1]) && t < 3000) begin
      if (feed > 0 && $urandom_range(0, 2) == 0) begin push($urandom); feed--; end
      tick(); t++;
    end
    if (t >= 3000) begin
      $display("FAIL timeout waiting for done got busy expected idle at cycle %0d", cyc);
      $fatal(1);
    end
    tick();
  endtask

  initial begin
    int t, n, pre;
    tick(3); rst_n = 1; tick(2);
    lit_last = 7; tp_chk = 1;
    for (int i = 0; i < 8; i++) push(i);
    go(8); wait_idle(0);
    lit_last = -1; tp_chk = 0;
    do_flush(); rmode = 1;
    for (int i = 0; i < 16; i++) push($urandom);
    go(16); wait_idle(0);
    do_flush(); rmode = 0; lit_last = 105;
    for (int i = 0; i < 3; i++) push(100 + i);
    go(6);
    t = 0;
    while ((rp[0] != wcnt || rp[1] != wcnt) && t < 100) begin tick(); t++; end
    tick(5);
    for (int i = 3; i < 6; i++) push(100 + i);
    wait_idle(0);
    lit_last = -1;
    do_flush(); go(0); wait_idle(0);
    do_flush();
    for (int i = 0; i < 10; i++) push(200 + i);
    go(10);
    t = 0;
    while (beats[0] < 4 && t < 200) begin tick(); t++; end
    rst_n = 0; tick(2); rst_n = 1; tick(2);
    do_flush(); push(300); push(301); lit_last = 301;
    go(2); wait_idle(0);
    lit_last = -1;
    do_flush(); tp_chk = 1;
    for (int i = 0; i < 32; i++) push($urandom);
    go(32); wait_idle(0);
    tp_chk = 0; rmode = 2; rbmode = 1;
    repeat (8) begin
      do_flush();
      n = $urandom_range(1, 20);
      pre = $urandom_range(0, n);
      for (int i = 0; i < pre; i++) push($urandom);
      go(n); wait_idle(n - pre);
    end
    rmode = 0; rbmode = 0; tick(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
